freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of a slow, asynchronous square wave (for example a divided game-tick clock or an external strobe) by counting its rising edges over a fixed gate window of system clocks.
- It is the receiving end of the clock-divider path: a divider produces the tick, and this block checks it.
- Used for self-test of timing chains and for rate checks on debug pins.
- The result is presented through a valid/ack holding register.

Parameters:
- GATE_CYCLES, 40000000: gate window length in clk_in cycles (≥2).
- CNT_W, 26: width of the edge counter and the result.
- SYNC_STAGES, 2: synchronizer flops on sig_in (≥2).

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  one-cycle pulse that begins a measurement when idle.
- continuous  input  1  when 1, a new gate starts immediately after each gate ends.
- result_ack  input  1  consumer acknowledge; clears result_valid.
- edge_count  output  CNT_W  rising edges counted in the last completed gate.
- overflow  output  1  edge counter saturated during the last completed gate.
- result_valid  output  1  edge_count is a new, unacknowledged result.
- overrun  output  1  sticky; a result was overwritten before it was acked.
- busy  output  1  a gate is in progress.

Behaviour:
- Reset: the clock is one clk_in domain; reset is asynchronous, active-high, and named rst.
  - All outputs reset to 0.
  - Synchronizer flops, previous-sample flop, gate counter and edge counter reset to 0.
  - State resets to IDLE.
  - Asserting rst mid-gate aborts the gate; no result is produced.
- Synchronizer and edge detect: sig_in passes through SYNC_STAGES flops, then one previous-sample flop. rise = sync_out & ~prev.
  - Latency from a sig_in rising edge to rise: SYNC_STAGES+1 clk_in cycles.
  - Pulses shorter than one clk_in period may be missed. This is a documented limitation.
- FSM states are IDLE and GATE.
- IDLE:
  - busy=0; rise is ignored.
  - start=1 moves to GATE and clears gate_cnt and edge_cnt.
- GATE:
  - busy=1 and gate_cnt increments every cycle.
  - On rise, edge_cnt increments, saturating at 2^CNT_W-1. An increment attempted at saturation sets an internal ovf flag.
  - start is ignored while in GATE.
- End of gate (gate_cnt == GATE_CYCLES-1):
  - A rise in this cycle is included in the count.
  - On the next edge, edge_count and overflow load the final values and result_valid is set to 1.
  - gate_cnt, edge_cnt and ovf clear.
  - If continuous=1 the FSM stays in GATE with no idle cycle; otherwise it returns to IDLE.
- Handshake:
  - result_valid stays 1 until a cycle with result_ack=1, then falls on the next edge.
  - result_ack while result_valid=0 has no effect.
- Simultaneous capture and result_ack: the capture wins. result_valid stays 1 and overrun is not set.
- Capture while result_valid=1 and result_ack=0: edge_count is overwritten and overrun is set.
  - overrun clears only on rst.
- edge_count and overflow hold their values until the next capture.

Optional Feature:
- Macro: FREQ_METER_PERIOD_EN.
- When defined:
  - Adds output period[31:0], the number of clk_in cycles between the last two rise events inside the gate.
  - period is captured with edge_count.
  - It is 0 if fewer than 2 rises occurred in the gate.
  - The internal period counter saturates at 2^32-1.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum (IDLE, GATE);
  - the default constants GATE_CYCLES_DEF=40000000, CNT_W_DEF=26, SYNC_STAGES_DEF=2.
- Sub-module sync_rise_detect: synchronizer chain plus previous-sample flop, producing a one-cycle rise pulse. It is reused for other asynchronous inputs such as buttons.

Test Plan:
- GATE_CYCLES=100, sig_in period 10 cycles, start pulse → one gate:
  - busy high for 100 cycles;
  - result_valid=1 with edge_count=10, overflow=0;
  - FSM returns to IDLE.
- CNT_W=3, GATE_CYCLES=100, sig_in period 4 cycles (25 edges) → edge_count=7, overflow=1.
- continuous=1, no result_ack, 3 gates → results arrive every 100 cycles with no gap, overrun=1 after the second capture, last edge_count is current.
- result_ack asserted in the same cycle as a capture → result_valid stays 1 and overrun stays 0.
  - result_ack one cycle later → result_valid=0 on the following edge.
- rst asserted at gate_cnt=50 → all outputs are 0 immediately (asynchronous). After release, start gives a full fresh 100-cycle gate with the correct count.
- With FREQ_METER_PERIOD_EN, sig_in period 10 → period=10. With a single edge in the gate → period=0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter.
package freq_meter_pkg;
  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_e;

  localparam int GATE_CYCLES_DEF = 40000000;
  localparam int CNT_W_DEF       = 26;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int PERIOD_W        = 32;
endpackage

// File: rtl/freq_meter_sync_rise_detect.sv
// Synchronizer chain plus previous-sample flop; emits a one-cycle pulse per rising edge
// of an asynchronous input. Pulses shorter than one clock period may be missed.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter with valid/ack result register.
// Optional FREQ_METER_PERIOD_EN adds the interval between the last two rises in the gate.
module freq_meter import freq_meter_pkg::*; #(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  input  logic             result_ack,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow,
  output logic             result_valid,
  output logic             overrun,
  output logic             busy
`ifdef FREQ_METER_PERIOD_EN
  ,output logic [PERIOD_W-1:0] period
`endif
);
  localparam int              GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic rise;
  sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_in), .rst_i(rst), .async_i(sig_in), .rise_o(rise)
  );

  state_e           state_q;
  logic [GW-1:0]    gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_count_q;
  logic             ovf_q, ovf_d, overflow_q, valid_q, overrun_q, busy_q;
  logic             gate_end;

  assign gate_end = (state_q == GATE) && (gate_cnt_q == GATE_LAST);

  // Counter value including this cycle's rise, so the final cycle's edge is captured.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                       edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (result_ack) valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q    <= GATE;
          busy_q     <= 1'b1;
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          ovf_q      <= 1'b0;
        end
        GATE: if (gate_end) begin
          edge_count_q <= edge_cnt_d;
          overflow_q   <= ovf_d;
          valid_q      <= 1'b1;   // capture beats a same-cycle ack
          if (valid_q && !result_ack) overrun_q <= 1'b1;
          gate_cnt_q   <= '0;
          edge_cnt_q   <= '0;
          ovf_q        <= 1'b0;
          if (!continuous) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end else begin
          gate_cnt_q <= gate_cnt_q + 1'b1;
          edge_cnt_q <= edge_cnt_d;
          ovf_q      <= ovf_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign edge_count   = edge_count_q;
  assign overflow     = overflow_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

`ifdef FREQ_METER_PERIOD_EN
  localparam logic [PERIOD_W-1:0] PRD_MAX = '1;
  logic [PERIOD_W-1:0] prd_cnt_q, prd_cnt_d, prd_last_q, prd_last_d, period_q;
  logic                seen_q, two_q, two_d;

  // prd_cnt_q holds cycles elapsed since the previous rise.
  always_comb begin
    prd_last_d = prd_last_q;
    two_d      = two_q;
    prd_cnt_d  = (prd_cnt_q == PRD_MAX) ? PRD_MAX : prd_cnt_q + 1'b1;
    if (rise) begin
      prd_cnt_d = 32'd1;
      if (seen_q) begin
        prd_last_d = prd_cnt_q;
        two_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      prd_cnt_q  <= '0;
      prd_last_q <= '0;
      seen_q     <= 1'b0;
      two_q      <= 1'b0;
      period_q   <= '0;
    end else if ((state_q == IDLE && start) || gate_end) begin
      if (gate_end) period_q <= two_d ? prd_last_d : '0;
      prd_cnt_q  <= '0;
      prd_last_q <= '0;
      seen_q     <= 1'b0;
      two_q      <= 1'b0;
    end else if (state_q == GATE) begin
      prd_cnt_q  <= prd_cnt_d;
      prd_last_q <= prd_last_d;
      two_q      <= two_d;
      if (rise) seen_q <= 1'b1;
    end
  end

  assign period = period_q;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench: main instance (CNT_W=26) and a narrow instance (CNT_W=3) share stimulus.
module tb_freq_meter;
  logic clk_in = 1'b0, rst = 1'b0, sig_in = 1'b0, start = 1'b0;
  logic continuous = 1'b0, result_ack = 1'b0;
  logic [25:0] edge_count;
  logic        overflow, result_valid, overrun, busy;
  logic [2:0]  edge_count_s;
  logic        overflow_s, result_valid_s, overrun_s, busy_s;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] period, period_s;
`endif
  int   checks = 0, fails = 0;
  int   sig_per = 0;
  logic sig_man = 1'b0;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(26), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .result_ack(result_ack), .edge_count(edge_count), .overflow(overflow),
    .result_valid(result_valid), .overrun(overrun), .busy(busy)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period)
`endif
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(3), .SYNC_STAGES(2)) dut_s (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .result_ack(result_ack), .edge_count(edge_count_s), .overflow(overflow_s),
    .result_valid(result_valid_s), .overrun(overrun_s), .busy(busy_s)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period_s)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Square wave of sig_per cycles (high for sig_per/2), or sig_man when sig_per == 0.
  initial begin : gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk_in); #1;
      if (sig_per == 0) sig_in = sig_man;
      else begin
        ph     = (ph + 1) % sig_per;
        sig_in = (ph < sig_per / 2);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if ({edge_count, overflow, result_valid, overrun, busy} !== '0) begin
      fails++; $display("FAIL reset_outputs: got ec=%0d ov=%b v=%b or=%b b=%b want all 0",
                        edge_count, overflow, result_valid, overrun, busy); end
    cyc(3); rst = 1'b0; cyc(2);
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, result_valid); end
  endtask

  task automatic test_single_gate();
    int n;
    sig_per = 10; continuous = 1'b0;
    cyc(30);
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 300) begin n++; cyc(1); end
    checks++; if (n != 100) begin
      fails++; $display("FAIL busy_cycles: got %0d want 100", n); end
    checks++; if (result_valid !== 1'b1 || edge_count !== 26'd10 || overflow !== 1'b0) begin
      fails++; $display("FAIL single_result: got v=%b ec=%0d ov=%b want 1 10 0",
                        result_valid, edge_count, overflow); end
    cyc(5);
    checks++; if (busy !== 1'b0 || result_valid !== 1'b1) begin
      fails++; $display("FAIL single_idle_hold: got busy=%b valid=%b want 0 1", busy, result_valid); end
    result_ack = 1'b1; cyc(1); result_ack = 1'b0;
    checks++; if (result_valid !== 1'b0) begin
      fails++; $display("FAIL ack_clear: got %b want 0", result_valid); end
    result_ack = 1'b1; cyc(1); result_ack = 1'b0;
    checks++; if (result_valid !== 1'b0 || edge_count !== 26'd10) begin
      fails++; $display("FAIL ack_idle_noeffect: got v=%b ec=%0d want 0 10", result_valid, edge_count); end
  endtask

  task automatic test_overflow();
    sig_per = 4;
    cyc(20);
    pulse_start();
    cyc(100);
    checks++; if (edge_count_s !== 3'd7 || overflow_s !== 1'b1) begin
      fails++; $display("FAIL narrow_sat: got ec=%0d ov=%b want 7 1", edge_count_s, overflow_s); end
    checks++; if (edge_count !== 26'd25 || overflow !== 1'b0 || result_valid !== 1'b1) begin
      fails++; $display("FAIL wide_25: got ec=%0d ov=%b v=%b want 25 0 1",
                        edge_count, overflow, result_valid); end
  endtask

  // result_valid is still 1 from the previous gate going into this capture.
  task automatic test_ack_capture();
    sig_per = 10;
    cyc(20);
    pulse_start();
    cyc(99);
    result_ack = 1'b1;
    cyc(1);
    checks++; if (result_valid !== 1'b1 || overrun !== 1'b0 || edge_count !== 26'd10) begin
      fails++; $display("FAIL ack_same_cycle: got v=%b or=%b ec=%0d want 1 0 10",
                        result_valid, overrun, edge_count); end
    cyc(1);
    result_ack = 1'b0;
    checks++; if (result_valid !== 1'b0) begin
      fails++; $display("FAIL ack_next_cycle: got %b want 0", result_valid); end
  endtask

  task automatic test_continuous();
    continuous = 1'b1; sig_per = 10;
    pulse_start();
    cyc(100);
    checks++; if (result_valid !== 1'b1 || edge_count !== 26'd10 || overrun !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL cont_gate1: got v=%b ec=%0d or=%b b=%b want 1 10 0 1",
                        result_valid, edge_count, overrun, busy); end
    cyc(50); sig_per = 5; cyc(50);
    checks++; if (overrun !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b1) begin
      fails++; $display("FAIL cont_gate2: got or=%b b=%b v=%b want 1 1 1", overrun, busy, result_valid); end
    continuous = 1'b0;
    cyc(100);
    checks++; if (edge_count !== 26'd20 || busy !== 1'b0 || result_valid !== 1'b1 || overrun !== 1'b1) begin
      fails++; $display("FAIL cont_gate3: got ec=%0d b=%b v=%b or=%b want 20 0 1 1",
                        edge_count, busy, result_valid, overrun); end
    result_ack = 1'b1; cyc(1); result_ack = 1'b0;
  endtask

  task automatic test_rst_mid_gate();
    sig_per = 10;
    pulse_start();
    cyc(50);
    rst = 1'b1;
    #1;
    checks++; if ({edge_count, overflow, result_valid, overrun, busy} !== '0) begin
      fails++; $display("FAIL rst_async: got ec=%0d ov=%b v=%b or=%b b=%b want all 0",
                        edge_count, overflow, result_valid, overrun, busy); end
    cyc(2); rst = 1'b0; cyc(80);
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      fails++; $display("FAIL rst_no_result: got busy=%b valid=%b want 0 0", busy, result_valid); end
    pulse_start();
    cyc(100);
    checks++; if (edge_count !== 26'd10 || result_valid !== 1'b1 || overrun !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_fresh_gate: got ec=%0d v=%b or=%b b=%b want 10 1 0 0",
                        edge_count, result_valid, overrun, busy); end
    result_ack = 1'b1; cyc(1); result_ack = 1'b0;
  endtask

`ifdef FREQ_METER_PERIOD_EN
  task automatic test_period();
    sig_per = 10;
    cyc(20);
    pulse_start();
    cyc(100);
    checks++; if (period !== 32'd10) begin
      fails++; $display("FAIL period_10: got %0d want 10", period); end
    result_ack = 1'b1; cyc(1); result_ack = 1'b0;
  endtask
`endif

  task automatic test_single_edge();
    sig_per = 0; sig_man = 1'b0;
    cyc(10);
    pulse_start();
    cyc(30); sig_man = 1'b1; cyc(70);
    checks++; if (edge_count !== 26'd1 || result_valid !== 1'b1) begin
      fails++; $display("FAIL single_edge: got ec=%0d v=%b want 1 1", edge_count, result_valid); end
`ifdef FREQ_METER_PERIOD_EN
    checks++; if (period !== 32'd0) begin
      fails++; $display("FAIL period_one_edge: got %0d want 0", period); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_gate();
    test_overflow();
    test_ack_capture();
    test_continuous();
    test_rst_mid_gate();
`ifdef FREQ_METER_PERIOD_EN
    test_period();
`endif
    test_single_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
